elm_frame_loader: RTL and testbench
===================================

Name: elm_frame_loader

Overview:
- Upstream stage of the ELM DATAPATH. Replaces the static INPUT_DATA image ROM with a live, double-buffered binary image store.
- Accepts an 8-bit grayscale pixel stream over a valid/ready handshake and thresholds each pixel to 1 bit.
- Fills one 256-bit bank while DATAPATH reads the other, bit-serially by address.
- Issues DATAPATH's start pulse and releases the read bank on OVER.

Parameters:
- NPIX, 256, pixels per frame (16x16 image); must equal 2**AW.
- AW, 8, read address width; matches DATAPATH add.
- PW, 8, input pixel width.
- THRESH, 128, binarisation threshold: bit = (pix_data >= THRESH).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- pix_data  in  PW  grayscale pixel.
- pix_valid  in  1  pixel present.
- pix_last  in  1  marks the final pixel of a frame; qualified by pix_valid.
- pix_ready  out  1  loader can accept a pixel.
- mem_addr  in  AW  bit address from DATAPATH add.
- data_out  out  1  addressed bit of the read bank; drives DATAPATH input_data.
- start  out  1  one-cycle start pulse to DATAPATH.
- over  in  1  DATAPATH OVER.
- frame_err  out  1  one-cycle pulse when a malformed frame is discarded.
- frame_cnt  out  8  count of completed classifications; wraps 255 -> 0.

Behaviour:
- Storage:
  - Two banks of NPIX bits, bank[0] and bank[1].
  - wsel selects the write bank; rsel = ~wsel selects the read bank.
- Reset (rst=0, asynchronous):
  - wptr=0, wsel=0, wfull=0, rstate=R_IDLE, armed=0.
  - start=0, data_out=0, frame_err=0, frame_cnt=0.
  - pix_ready=1, because it derives from wfull. Bank contents are don't-care.
  - Reset mid-frame or mid-classification abandons all work; no start or frame_err is emitted for the abandoned frame.
- Write side:
  - pix_ready = ~wfull, decoded from registers only; no combinational path from pix_valid.
  - Accept occurs on a rising edge with pix_valid & pix_ready. On accept, bank[wsel][wptr] <= (pix_data >= THRESH).
  - Accept with wptr < NPIX-1 and pix_last=0: wptr++.
  - Accept with wptr = NPIX-1 and pix_last=1: wfull<=1, wptr<=0.
  - Accept with pix_last=1 and wptr < NPIX-1 (short frame): discard, wptr<=0, frame_err=1 for one cycle.
  - Accept with wptr = NPIX-1 and pix_last=0 (long frame): discard, wptr<=0, frame_err=1 for one cycle. Subsequent pixels begin a new frame at address 0.
- Read-side state machine (rstate):
  - R_IDLE, when wfull=1:
    - Swap: wsel<=~wsel, wfull<=0.
    - start<=1 (high exactly one cycle).
    - armed<=0, go to R_BUSY.
  - R_BUSY, arming: if over=0, armed<=1. This guards against a stale OVER level left from the previous frame.
  - R_BUSY, completion: if armed & over, go to R_IDLE and frame_cnt++. The read bank is then free.
  - R_BUSY with wfull=1: hold; pix_ready stays 0 until the swap.
  - R_BUSY completion and wfull=1 on the same edge: go to R_IDLE. The swap occurs on the next edge, so start is at least 1 idle cycle after completion.
- Latency:
  - Final accept at edge E, read side idle: pix_ready low for exactly one cycle (E to E+1). Swap at E+1; start high E+1 to E+2.
- Read port:
  - data_out <= bank[rsel][mem_addr] on every rising edge: 1-cycle registered latency, the same as the existing memory.
  - Reads are valid throughout R_BUSY. In R_IDLE, data_out reflects the last read bank and is don't-care to DATAPATH.
  - Writes never touch bank[rsel].

Test Plan:
1. Reset, then stream 256 pixels alternating 0x00/0xFF with pix_last on #255 -> pix_ready low 1 cycle, start high 1 cycle at E+1. Reading addr 0,1,2 gives data_out 0,1,0, one cycle after each address.
2. Hold over=1 through start, drop it for 3 cycles, then raise it -> frame_cnt 0 -> 1 only on the re-rise. A stale high over does not complete the frame.
3. Stream frame A, then frame B while A is busy (over=0) -> B is accepted, pix_ready=0 after B's last pixel. Reads during this time still return A. Raise over -> next start, reads return B (pixel 0x80 -> 1, 0x7F -> 0 at THRESH=128).
4. pix_last on pixel #99 -> frame_err one-cycle pulse, no start. Next 256-pixel frame lands at addresses 0..255 and starts normally.
5. 256 pixels without pix_last -> frame_err on accept #255, no start. 300 completed frames -> frame_cnt=44.
6. Assert rst=0 asynchronously mid-frame (wptr=120) and mid-R_BUSY -> all outputs immediately at reset values, pix_ready=1. After release, a full frame produces start with frame_cnt=0.

Source files
------------

// File: rtl/elm_frame_loader.sv
// Double-buffered binary image store feeding the ELM datapath: thresholds an
// 8-bit pixel stream into one 256-bit bank while the datapath reads the other.
module elm_frame_loader #(
    parameter int NPIX   = 256,
    parameter int AW     = 8,
    parameter int PW     = 8,
    parameter int THRESH = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pix_data,
    input  logic          pix_valid,
    input  logic          pix_last,
    output logic          pix_ready,
    input  logic [AW-1:0] mem_addr,
    output logic          data_out,
    output logic          start,
    input  logic          over,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);

    // Handshake: a pixel transfers on a rising edge where pix_valid & pix_ready;
    // pix_ready is a pure register decode and never looks at pix_valid.

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rstate_e;

    localparam logic [AW-1:0] LAST_PTR = AW'(NPIX - 1);
    localparam logic [PW-1:0] THRESH_V = PW'(THRESH);

    logic [NPIX-1:0] bank_q [2];

    logic [AW-1:0] wptr_q, wptr_d;
    logic          wsel_q, wsel_d;
    logic          wfull_q, wfull_d;
    logic          armed_q, armed_d;
    logic          start_q, start_d;
    logic          data_out_q, data_out_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    rstate_e       rstate_q, rstate_d;

    logic accept;
    logic at_end;
    logic pix_bit;
    logic do_swap;
    logic do_done;
    logic do_arm;

    // ------------------------------------------------------------------
    // Read-side FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate_q <= R_IDLE;
        end else begin
            rstate_q <= rstate_d;
        end
    end

    // Read-side FSM: next state
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE: if (wfull_q) rstate_d = R_BUSY;
            R_BUSY: if (armed_q && over) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read-side FSM: actions. A pending full bank is only swapped from IDLE,
    // so completion and the next start are always separated by an idle cycle.
    always_comb begin
        do_swap = 1'b0;
        do_done = 1'b0;
        do_arm  = 1'b0;
        case (rstate_q)
            R_IDLE: do_swap = wfull_q;
            R_BUSY: begin
                do_done = armed_q & over;
                do_arm  = ~over;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write side and read-side bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        accept  = pix_valid & ~wfull_q;
        at_end  = (wptr_q == LAST_PTR);
        pix_bit = (pix_data >= THRESH_V);

        wptr_d      = wptr_q;
        wfull_d     = wfull_q;
        frame_err_d = 1'b0;
        if (accept) begin
            if (at_end && pix_last) begin
                wptr_d  = '0;
                wfull_d = 1'b1;
            end else if (at_end || pix_last) begin
                // Short or long frame: drop it and restart at address 0.
                wptr_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                wptr_d = wptr_q + 1'b1;
            end
        end
        if (do_swap) wfull_d = 1'b0;

        wsel_d = wsel_q ^ do_swap;

        // armed blocks a stale OVER level left high from the previous frame.
        armed_d = armed_q;
        if (do_swap) begin
            armed_d = 1'b0;
        end else if (do_arm) begin
            armed_d = 1'b1;
        end

        start_d     = do_swap;
        frame_cnt_d = frame_cnt_q + {7'd0, do_done};
        data_out_d  = bank_q[~wsel_q][mem_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            wsel_q      <= 1'b0;
            wfull_q     <= 1'b0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            data_out_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            wptr_q      <= wptr_d;
            wsel_q      <= wsel_d;
            wfull_q     <= wfull_d;
            armed_q     <= armed_d;
            start_q     <= start_d;
            data_out_q  <= data_out_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Bank contents are not reset; only the write bank is ever written.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[wsel_q][wptr_q] <= pix_bit;
        end
    end

    assign pix_ready = ~wfull_q;
    assign data_out  = data_out_q;
    assign start     = start_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_elm_frame_loader.sv
// Directed/randomised bench for elm_frame_loader with a frame-level image model.
module tb_elm_frame_loader;

    localparam int NPIX   = 256;
    localparam int AW     = 8;
    localparam int PW     = 8;
    localparam int THRESH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_last = 1'b0;
    logic          pix_ready;
    logic [AW-1:0] mem_addr = '0;
    logic          data_out;
    logic          start;
    logic          over = 1'b0;
    logic          frame_err;
    logic [7:0]    frame_cnt;

    elm_frame_loader #(.NPIX(NPIX), .AW(AW), .PW(PW), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last),
        .pix_ready(pix_ready),
        .mem_addr(mem_addr), .data_out(data_out),
        .start(start), .over(over),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int exp_cnt = 0;
    int completions = 0;

    // Scoreboard: images of well-formed frames awaiting their start pulse.
    logic [NPIX-1:0] exp_q[$];
    logic [NPIX-1:0] cur_img = '0;
    logic [PW-1:0]   fpix[NPIX];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every start hands the oldest loaded image to the read side.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (start === 1'b1) begin
                start_cnt++;
                check("start_has_frame", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) cur_img = exp_q.pop_front();
            end
            if (frame_err === 1'b1) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NPIX-1:0] img_of();
        logic [NPIX-1:0] img;
        for (int i = 0; i < NPIX; i++) img[i] = (int'(fpix[i]) >= THRESH);
        return img;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) fpix[i] = PW'($urandom_range(0, 255));
    endtask

    task automatic send_pix(input logic [PW-1:0] d, input logic last);
        int waited = 0;
        pix_data  = d;
        pix_valid = 1'b1;
        pix_last  = last;
        while (pix_ready !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        if (waited >= 2000) check("pix_ready_timeout", pix_ready, 1);
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_idx);
        for (int i = 0; i < n; i++) send_pix(fpix[i], i == last_idx);
    endtask

    task automatic wait_start();
        int s0 = start_cnt;
        for (int k = 0; k < 50 && start_cnt == s0; k++) tick();
        check("start_seen", start_cnt > s0, 1);
    endtask

    task automatic read_check(input int addr);
        mem_addr = AW'(addr);
        tick();
        check("read_bit", data_out, cur_img[addr]);
    endtask

    task automatic complete();
        over = 1'b0;
        tick();
        over = 1'b1;
        tick();
        over = 1'b0;
        completions++;
        exp_cnt = completions % 256;
        check("frame_cnt", frame_cnt, exp_cnt);
    endtask

    initial begin
        int s0;
        int e0;

        // Reset values
        repeat (3) tick();
        check("rst_pix_ready", pix_ready, 1);
        check("rst_start", start, 0);
        check("rst_data_out", data_out, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        tick();

        // Alternating 0x00/0xFF frame, exact handshake/start timing
        over = 1'b1;
        for (int i = 0; i < NPIX; i++) fpix[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
        send_frame(NPIX - 1, -1);
        exp_q.push_back(img_of());
        pix_data = fpix[NPIX-1]; pix_valid = 1'b1; pix_last = 1'b1;
        tick();
        pix_valid = 1'b0; pix_last = 1'b0;
        check("t1_ready_after_last", pix_ready, 0);
        check("t1_start_at_E", start, 0);
        tick();
        check("t1_ready_E1", pix_ready, 1);
        check("t1_start_E1", start, 1);
        tick();
        check("t1_start_E2", start, 0);
        mem_addr = 8'd0; tick(); check("t1_rd0", data_out, 0);
        mem_addr = 8'd1; tick(); check("t1_rd1", data_out, 1);
        mem_addr = 8'd2; tick(); check("t1_rd2", data_out, 0);
        for (int k = 0; k < 4; k++) read_check($urandom_range(0, NPIX - 1));

        // Stale OVER high must not complete; only the re-rise does
        repeat (5) tick();
        check("t2_stale_over", frame_cnt, 0);
        over = 1'b0;
        repeat (3) tick();
        check("t2_low_over", frame_cnt, 0);
        over = 1'b1;
        tick();
        over = 1'b0;
        completions++;
        exp_cnt = completions;
        check("t2_rerise", frame_cnt, exp_cnt);

        // Frame B loads while frame A is being read
        fill_random();
        send_frame(NPIX, NPIX - 1);
        exp_q.push_back(img_of());
        wait_start();
        s0 = start_cnt;
        fill_random();
        fpix[0] = 8'h80; fpix[1] = 8'h7F; fpix[2] = 8'h00; fpix[3] = 8'hFF;
        send_frame(NPIX, NPIX - 1);
        exp_q.push_back(img_of());
        check("t3_ready_held", pix_ready, 0);
        repeat (3) tick();
        check("t3_ready_still", pix_ready, 0);
        check("t3_no_start", start_cnt, s0);
        for (int k = 0; k < 6; k++) read_check($urandom_range(0, NPIX - 1));
        over = 1'b1;
        tick();
        over = 1'b0;
        completions++;
        exp_cnt = completions;
        check("t3_cnt_a", frame_cnt, exp_cnt);
        check("t3_idle_gap", start, 0);
        tick();
        check("t3_start_b", start, 1);
        check("t3_ready_b", pix_ready, 1);
        tick();
        mem_addr = 8'd0; tick(); check("t3_b_0x80", data_out, 1);
        mem_addr = 8'd1; tick(); check("t3_b_0x7f", data_out, 0);
        read_check(3);
        for (int k = 0; k < 4; k++) read_check($urandom_range(0, NPIX - 1));
        complete();

        // Short frame: pix_last on pixel #99
        s0 = start_cnt;
        e0 = err_cnt;
        fill_random();
        send_frame(99, -1);
        pix_data = fpix[99]; pix_valid = 1'b1; pix_last = 1'b1;
        tick();
        pix_valid = 1'b0; pix_last = 1'b0;
        check("t4_err_pulse", frame_err, 1);
        tick();
        check("t4_err_drop", frame_err, 0);
        repeat (4) tick();
        check("t4_no_start", start_cnt, s0);
        check("t4_err_count", err_cnt, e0 + 1);
        fill_random();
        send_frame(NPIX, NPIX - 1);
        exp_q.push_back(img_of());
        wait_start();
        read_check(0);
        read_check(NPIX - 1);
        for (int k = 0; k < 4; k++) read_check($urandom_range(0, NPIX - 1));
        complete();

        // Long frame: no pix_last within 256 pixels
        s0 = start_cnt;
        fill_random();
        send_frame(NPIX - 1, -1);
        pix_data = fpix[NPIX-1]; pix_valid = 1'b1; pix_last = 1'b0;
        tick();
        pix_valid = 1'b0;
        check("t5_err_pulse", frame_err, 1);
        check("t5_ready", pix_ready, 1);
        tick();
        check("t5_err_drop", frame_err, 0);
        repeat (4) tick();
        check("t5_no_start", start_cnt, s0);

        // Many frames so that frame_cnt wraps past 255
        while (completions < 260) begin
            fill_random();
            send_frame(NPIX, NPIX - 1);
            exp_q.push_back(img_of());
            wait_start();
            read_check($urandom_range(0, NPIX - 1));
            complete();
        end
        check("t5_wrapped_cnt", frame_cnt, 4);

        // Asynchronous reset mid-classification and mid-frame
        fill_random();
        send_frame(NPIX, NPIX - 1);
        exp_q.push_back(img_of());
        wait_start();
        fill_random();
        send_frame(120, -1);
        e0 = err_cnt;
        #2;
        rst = 1'b0;
        #1;
        check("t6_ready", pix_ready, 1);
        check("t6_start", start, 0);
        check("t6_err", frame_err, 0);
        check("t6_cnt", frame_cnt, 0);
        check("t6_data_out", data_out, 0);
        exp_q.delete();
        completions = 0;
        exp_cnt = 0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        s0 = start_cnt;
        fill_random();
        send_frame(NPIX, NPIX - 1);
        exp_q.push_back(img_of());
        wait_start();
        check("t6_start_once", start_cnt, s0 + 1);
        check("t6_cnt_after", frame_cnt, 0);
        check("t6_no_err", err_cnt, e0);
        for (int k = 0; k < 4; k++) read_check($urandom_range(0, NPIX - 1));
        complete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
